// File: rtl/matrix_host_pkg.sv
// -----------------------------------------------------------------------------
// matrix_host_pkg
//
// Shared definitions for the host-side sequencer of the 2x2 BRAM matrix
// multiplier.
//
// Contents:
//   state_t            - sequencer states (LOAD, RUN, RD_ADDR, RD_CAP, OUT)
//   X_BASE_DEF         - default first BRAM address of operand X
//   Y_BASE_DEF         - default first BRAM address of operand Y
//   OUT_BASE_DEF       - default first BRAM address of the result
//   WORDS_PER_MATRIX   - words in one 2x2 matrix (row-major)
//   OPERAND_WORDS      - words streamed in per batch (X then Y)
//   TIMER_W            - width of the compute-window timer
//   last_operand_word  - true for the index of the final operand word
// -----------------------------------------------------------------------------
package matrix_host_pkg;

  // Sequencer states.
  // RD_ADDR issues the port-B read. RD_CAP waits out the one-cycle BRAM
  // latency and captures the word. OUT presents the word downstream.
  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    RUN     = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    OUT     = 3'd4
  } state_t;

  localparam int X_BASE_DEF       = 0;
  localparam int Y_BASE_DEF       = 4;
  localparam int OUT_BASE_DEF     = 8;
  localparam int WORDS_PER_MATRIX = 4;
  localparam int OPERAND_WORDS    = 2 * WORDS_PER_MATRIX;
  localparam int TIMER_W          = 16;

  // The write counter is 3 bits wide and counts operand words 0..7.
  // This flags the word that completes the Y operand.
  function automatic logic last_operand_word(input logic [2:0] idx);
    return idx == 3'(OPERAND_WORDS - 1);
  endfunction

endpackage : matrix_host_pkg

// File: rtl/matrix_bram_host_down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable down-counter that times the multiplier compute window. It stops
// at zero instead of wrapping. is_one tells the caller that the current cycle
// is the last cycle of the window.
//
// Ports:
//   clk       in   sole clock, posedge
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val this cycle (takes priority over en)
//   load_val  in   WIDTH-bit value to load
//   en        in   decrement this cycle (ignored at zero)
//   is_one    out  count currently equals 1
// -----------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             is_one
);

  logic [WIDTH-1:0] count;

  // A load wins over a decrement. The counter stays at zero so that a
  // stray enable after expiry cannot wrap it back to the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule : down_counter

// File: rtl/matrix_bram_host.sv
// -----------------------------------------------------------------------------
// matrix_bram_host
//
// Host-side sequencer for the 2x2 BRAM matrix multiplier.
//  1. Accepts 8 operand words (X00 X01 X10 X11 Y00 Y01 Y10 Y11) on a
//     valid/ready stream and writes them through BRAM port B.
//  2. Releases the multiplier from reset for WAIT_CYCLES cycles.
//  3. Reads the 4 result words back and presents them on a valid/ready
//     output stream.
// The multiplier owns BRAM port A. This block only ever drives port B.
//
// Ports:
//   clk         in   sole clock, posedge
//   rst         in   synchronous active-high reset
//   s_data      in   operand word
//   s_valid     in   operand word valid
//   s_ready     out  operand accepted when s_valid & s_ready
//   m_data      out  result word (registered, stable while m_valid)
//   m_valid     out  result word valid
//   m_ready     in   result consumer ready
//   mm_rst      out  multiplier reset, high = multiplier held idle
//   batch_done  out  one-cycle strobe on the 4th result handshake
//   BRAM_addr   out  port-B address
//   BRAM_clk    out  port-B clock (= clk)
//   BRAM_din    out  port-B write data
//   BRAM_dout   in   port-B read data, one-cycle registered latency
//   BRAM_en     out  port-B enable
//   BRAM_we     out  port-B write enable
// -----------------------------------------------------------------------------
module matrix_bram_host
  import matrix_host_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int X_BASE      = X_BASE_DEF,
  parameter int Y_BASE      = Y_BASE_DEF,
  parameter int OUT_BASE    = OUT_BASE_DEF,
  parameter int WAIT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              mm_rst,
  output logic              batch_done,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic              BRAM_clk,
  output logic [DATA_W-1:0] BRAM_din,
  input  logic [DATA_W-1:0] BRAM_dout,
  output logic              BRAM_en,
  output logic              BRAM_we
);

  // Base addresses reduced to the BRAM address width, so all address
  // arithmetic below wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0]  X_ADDR   = ADDR_W'(X_BASE);
  localparam logic [ADDR_W-1:0]  Y_ADDR   = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0]  OUT_ADDR = ADDR_W'(OUT_BASE);
  localparam logic [TIMER_W-1:0] WAIT_VAL = TIMER_W'(WAIT_CYCLES);
  localparam logic [1:0]         LAST_RD  = 2'(WORDS_PER_MATRIX - 1);

  state_t            state;
  logic [2:0]        wcnt;
  logic [1:0]        rcnt;
  logic              load_hs;
  logic              out_hs;
  logic              timer_load;
  logic              timer_one;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  assign BRAM_clk = clk;

  // Operand acceptance is combinational so that the load runs at one word
  // per cycle. Gating with rst keeps s_ready low, and blocks any port-B
  // write, during the reset cycle itself.
  assign s_ready = (state == LOAD) && !rst;
  assign load_hs = s_ready && s_valid;
  assign out_hs  = (state == OUT) && m_ready && !rst;

  // Write counter 0..3 lands in X and 4..7 lands in Y. Bit 2 picks the
  // matrix and the low two bits give the row-major offset within it.
  assign wr_addr = wcnt[2] ? (Y_ADDR + ADDR_W'(wcnt[1:0]))
                           : (X_ADDR + ADDR_W'(wcnt[1:0]));
  assign rd_addr = OUT_ADDR + ADDR_W'(rcnt);

  // Port-B strobes. A write happens in a LOAD handshake cycle. A read
  // happens in every RD_ADDR cycle. The port is idle otherwise.
  always_comb begin
    BRAM_en = 1'b0;
    BRAM_we = 1'b0;
    if (load_hs) begin
      BRAM_en = 1'b1;
      BRAM_we = 1'b1;
    end else if ((state == RD_ADDR) && !rst) begin
      BRAM_en = 1'b1;
    end
  end

  // Address and write data follow the active access. When the port is
  // idle they hold the last driven value, which keeps the bus quiet.
  always_comb begin
    BRAM_addr = addr_q;
    BRAM_din  = din_q;
    if (load_hs) begin
      BRAM_addr = wr_addr;
      BRAM_din  = s_data;
    end else if ((state == RD_ADDR) && !rst) begin
      BRAM_addr = rd_addr;
    end
  end

  // Register the driven address and data so that the idle cycles can
  // repeat them.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      addr_q <= BRAM_addr;
      din_q  <= BRAM_din;
    end
  end

  // The strobe fires in the cycle of the final result handshake, so s_ready
  // comes back one cycle later, when the FSM has returned to LOAD.
  assign batch_done = out_hs && (rcnt == LAST_RD);

  // The compute-window timer is loaded on the last operand handshake, so it
  // already holds WAIT_CYCLES in the first RUN cycle. RUN therefore lasts
  // exactly WAIT_CYCLES cycles: the timer reads WAIT_CYCLES down to 1.
  assign timer_load = load_hs && last_operand_word(wcnt);

  down_counter #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (WAIT_VAL),
    .en       (state == RUN),
    .is_one   (timer_one)
  );

  // Main sequencer. mm_rst, m_valid and m_data are registered here.
  // - mm_rst drops on the transition into RUN and rises on the way out.
  // - m_valid is set on the way into OUT and cleared by the handshake.
  // Because of this, m_valid is high exactly while the FSM sits in OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      wcnt    <= '0;
      rcnt    <= '0;
      mm_rst  <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_hs) begin
            // wcnt wraps 7 -> 0, which clears it for the next batch.
            wcnt <= wcnt + 3'd1;
            if (last_operand_word(wcnt)) begin
              state  <= RUN;
              mm_rst <= 1'b0;
            end
          end
        end
        RUN: begin
          if (timer_one) begin
            state  <= RD_ADDR;
            rcnt   <= '0;
            mm_rst <= 1'b1;
          end
        end
        RD_ADDR: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          // The read data becomes visible one cycle after the address.
          m_data  <= BRAM_dout;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (rcnt == LAST_RD) begin
              state <= LOAD;
            end else begin
              rcnt  <= rcnt + 2'd1;
              state <= RD_ADDR;
            end
          end
        end
        default: begin
          state  <= LOAD;
          mm_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule : matrix_bram_host

// File: tb/tb_matrix_bram_host.sv
// -----------------------------------------------------------------------------
// tb_matrix_bram_host
//
// Self-checking bench for matrix_bram_host.
// The BRAM model also plays the multiplier: while mm_rst is low it computes
// the 2x2 product from whatever X and Y the DUT wrote, and stores the result
// at addresses 8..11. Expected results come from a table of constants or
// from a matrix-product reference function. Timing expectations come from
// the protocol rules as cycle arithmetic.
// A second instance with WAIT_CYCLES=1 covers the shortest compute window.
// -----------------------------------------------------------------------------
module tb_matrix_bram_host;

  localparam int WAIT = 64;

  typedef logic [3:0][31:0] mat_t;

  typedef struct {
    mat_t x;
    mat_t y;
    bit   gaps;
    int   bp_word;
    mat_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        mm_rst;
  logic        batch_done;
  logic [12:0] bram_addr;
  logic        bram_clk;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic        bram_en;
  logic        bram_we;

  logic        rst1;
  logic [31:0] s_data1;
  logic        s_valid1;
  logic        s_ready1;
  logic [31:0] m_data1;
  logic        m_valid1;
  logic        m_ready1;
  logic        mm_rst1;
  logic        batch_done1;
  logic [12:0] bram_addr1;
  logic        bram_clk1;
  logic [31:0] bram_din1;
  logic [31:0] bram_dout1;
  logic        bram_en1;
  logic        bram_we1;

  int vec_count  = 0;
  int miss_count = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_bram_host #(
    .ADDR_W(13), .DATA_W(32), .X_BASE(0), .Y_BASE(4), .OUT_BASE(8), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .mm_rst(mm_rst),
    .batch_done(batch_done), .BRAM_addr(bram_addr), .BRAM_clk(bram_clk),
    .BRAM_din(bram_din), .BRAM_dout(bram_dout), .BRAM_en(bram_en), .BRAM_we(bram_we)
  );

  matrix_bram_host #(
    .ADDR_W(13), .DATA_W(32), .X_BASE(0), .Y_BASE(4), .OUT_BASE(8), .WAIT_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .mm_rst(mm_rst1),
    .batch_done(batch_done1), .BRAM_addr(bram_addr1), .BRAM_clk(bram_clk1),
    .BRAM_din(bram_din1), .BRAM_dout(bram_dout1), .BRAM_en(bram_en1), .BRAM_we(bram_we1)
  );

  // BRAM port B (read-first, 1-cycle latency). The multiplier stand-in
  // recomputes the product every cycle that mm_rst is low.
  logic [31:0] mem  [0:8191];
  logic [31:0] mem1 [0:8191];

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
    end
    if (!mm_rst)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          mem[8+2*i+j] <= mem[2*i]*mem[4+j] + mem[2*i+1]*mem[6+j];
  end

  always @(posedge clk) begin
    if (bram_en1) begin
      if (bram_we1) mem1[bram_addr1] <= bram_din1;
      bram_dout1 <= mem1[bram_addr1];
    end
    if (!mm_rst1)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          mem1[8+2*i+j] <= mem1[2*i]*mem1[4+j] + mem1[2*i+1]*mem1[6+j];
  end

  // Monitor, sampled on the falling edge.
  int          hs_count;
  int          hs8_cyc;
  logic [12:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          rd_count;
  int          mm_fall_cyc;
  int          mm_rise_cyc;
  int          mm_runs [$];
  logic        mm_prev = 1'b1;
  int          first_valid_cyc;
  logic [31:0] out_q [$];
  int          out_cyc_q [$];
  int          bd_count;
  int          bd_cyc;
  int          sr_rise_cyc;
  logic        sr_prev = 1'b0;
  int          clk_bad = 0;

  always @(negedge clk) begin
    if (s_valid && s_ready) begin
      hs_count++;
      if (hs_count == 8) hs8_cyc = cyc;
    end
    if (bram_en && bram_we) begin
      wr_addr_q.push_back(bram_addr);
      wr_data_q.push_back(bram_din);
    end
    if (bram_en && !bram_we) rd_count++;
    if (!mm_rst && mm_prev) mm_fall_cyc = cyc;
    if (mm_rst && !mm_prev) begin
      mm_rise_cyc = cyc;
      mm_runs.push_back(cyc - mm_fall_cyc);
    end
    mm_prev = mm_rst;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      out_cyc_q.push_back(cyc);
    end
    if (batch_done) begin
      bd_count++;
      bd_cyc = cyc;
    end
    if (s_ready && !sr_prev) sr_rise_cyc = cyc;
    sr_prev = s_ready;
    if (bram_clk !== clk) clk_bad++;
  end

  int          low1 = 0;
  int          bd1  = 0;
  logic [31:0] out1_q [$];

  always @(negedge clk) begin
    if (!rst1 && !mm_rst1) low1++;
    if (m_valid1 && m_ready1) out1_q.push_back(m_data1);
    if (batch_done1) bd1++;
    if (bram_clk1 !== clk) clk_bad++;
  end

  // Reference model: the plain 2x2 matrix product (row-major, 32-bit wrap).
  function automatic mat_t mat_prod(input mat_t x, input mat_t y);
    mat_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        r[2*i+j] = 32'd0;
        for (int k = 0; k < 2; k++) r[2*i+j] += x[2*i+k] * y[2*k+j];
      end
    return r;
  endfunction

  function automatic mat_t mk(input int a, input int b, input int c, input int d);
    mat_t r;
    r[0] = 32'(a); r[1] = 32'(b); r[2] = 32'(c); r[3] = 32'(d);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    hs_count = 0; hs8_cyc = -1; rd_count = 0;
    wr_addr_q.delete(); wr_data_q.delete();
    mm_fall_cyc = -1; mm_rise_cyc = -1; mm_runs.delete();
    first_valid_cyc = -1; out_q.delete(); out_cyc_q.delete();
    bd_count = 0; bd_cyc = -1; sr_rise_cyc = -1;
  endtask

  task automatic sendWord(input logic [31:0] d);
    bit done = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = s_ready;
      tick();
    end
    if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  // Streams X then Y. With gaps set, s_valid toggles every other cycle.
  task automatic applyStimulus(input mat_t x, input mat_t y, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      sendWord(i < 4 ? x[i] : y[i-4]);
      if (gaps) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  // Drains the result stream. Optionally it stalls 10 cycles on word bp_word
  // and checks that the held word stays put.
  task automatic drain(input int bp_word, input mat_t exp);
    int          hold = 0;
    int          unstable = 0;
    logic [31:0] held = '0;
    m_ready = 1'b1;
    for (int t = 0; t < 400 && bd_count == 0; t++) begin
      if (bp_word >= 0 && m_valid && out_q.size() == bp_word && hold < 10) begin
        if (hold == 0) held = m_data;
        else if (m_data !== held || !m_valid) unstable++;
        m_ready = 1'b0;
        hold++;
      end else begin
        m_ready = 1'b1;
      end
      tick();
    end
    m_ready = 1'b0;
    checkOutput("drain_done", 32'(bd_count > 0), 32'd1);
    if (bp_word >= 0) begin
      checkOutput("bp_hold_len", 32'(hold), 32'd10);
      checkOutput("bp_held_data", held, exp[bp_word]);
      checkOutput("bp_unstable", 32'(unstable), 32'd0);
    end
  endtask

  task automatic checkBatch(input mat_t x, input mat_t y, input mat_t exp, input int bp_word);
    checkOutput("wr_count", 32'(wr_addr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      checkOutput("wr_addr", 32'(wr_addr_q[i]), 32'(i));
      checkOutput("wr_data", wr_data_q[i], i < 4 ? x[i] : y[i-4]);
    end
    checkOutput("mm_run_count", 32'(mm_runs.size()), 32'd1);
    if (mm_runs.size() > 0) checkOutput("mm_low_len", 32'(mm_runs[0]), 32'(WAIT));
    checkOutput("mm_fall_timing", 32'(mm_fall_cyc), 32'(hs8_cyc + 1));
    checkOutput("first_valid_timing", 32'(first_valid_cyc), 32'(mm_rise_cyc + 2));
    checkOutput("out_count", 32'(out_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) checkOutput("m_data", out_q[i], exp[i]);
    checkOutput("batch_done_count", 32'(bd_count), 32'd1);
    if (out_cyc_q.size() == 4) checkOutput("batch_done_timing", 32'(bd_cyc), 32'(out_cyc_q[3]));
    checkOutput("s_ready_rise", 32'(sr_rise_cyc), 32'(bd_cyc + 1));
    checkOutput("read_count", 32'(rd_count), 32'd4);
    if (bp_word < 0)
      for (int i = 0; i + 1 < out_cyc_q.size(); i++)
        checkOutput("drain_spacing", 32'(out_cyc_q[i+1] - out_cyc_q[i]), 32'd3);
  endtask

  task automatic runBatch(input vec_t v);
    clearMon();
    applyStimulus(v.x, v.y, v.gaps);
    drain(v.bp_word, v.exp);
    tick();
    checkBatch(v.x, v.y, v.exp, v.bp_word);
  endtask

  function automatic vec_t randVec();
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.x[i] = $urandom_range(0, 5000);
      v.y[i] = $urandom_range(0, 5000);
    end
    v.gaps    = 1'($urandom_range(0, 1));
    v.bp_word = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
    v.exp     = mat_prod(v.x, v.y);
    return v;
  endfunction

  vec_t tbl [4];

  initial begin
    vec_t v;
    bit   seen;

    tbl[0] = '{x: mk(1,2,3,4), y: mk(5,6,7,8), gaps: 1'b0, bp_word: -1, exp: mk(19,22,43,50)};
    tbl[1] = '{x: mk(1,2,3,4), y: mk(5,6,7,8), gaps: 1'b1, bp_word: -1, exp: mk(19,22,43,50)};
    tbl[2] = '{x: mk(1,2,3,4), y: mk(5,6,7,8), gaps: 1'b0, bp_word:  1, exp: mk(19,22,43,50)};
    tbl[3] = '{x: mk(2,0,0,2), y: mk(3,4,5,6), gaps: 1'b1, bp_word: -1, exp: mk(6,8,10,12)};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    rst1 = 1'b1; s_valid1 = 1'b0; s_data1 = '0; m_ready1 = 1'b0;
    clearMon();

    // Reset state, with s_valid asserted to show nothing is accepted.
    tick(); tick();
    s_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_mm_rst", 32'(mm_rst), 32'd1);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_batch_done", 32'(batch_done), 32'd0);
    checkOutput("rst_bram_en", 32'(bram_en), 32'd0);
    checkOutput("rst_bram_we", 32'(bram_we), 32'd0);
    tick();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) runBatch(tbl[i]);

    $display("[TB] random batches");
    for (int i = 0; i < 4; i++) runBatch(randVec());

    // Reset during the operand load.
    $display("[TB] reset mid-load");
    clearMon();
    for (int i = 0; i < 5; i++) sendWord(32'(100 + i));
    s_data = 32'd999; s_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    checkOutput("midload_no_write", 32'(bram_en | bram_we), 32'd0);
    checkOutput("midload_wr_count", 32'(wr_addr_q.size()), 32'd5);
    tick();
    rst = 1'b0; s_valid = 1'b0;
    tick();
    runBatch(randVec());

    // Reset during the compute window.
    $display("[TB] reset in RUN");
    clearMon();
    v = randVec();
    applyStimulus(v.x, v.y, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("run_entered", 32'(mm_rst), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("run_rst_mm_rst", 32'(mm_rst), 32'd1);
    checkOutput("run_rst_m_valid", 32'(m_valid), 32'd0);
    tick();
    runBatch(randVec());

    // Reset while a result word is waiting to be taken.
    $display("[TB] reset in OUT");
    clearMon();
    v = randVec();
    applyStimulus(v.x, v.y, 1'b0);
    m_ready = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      seen = m_valid;
      if (!seen) tick();
    end
    checkOutput("out_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("out_rst_mm_rst", 32'(mm_rst), 32'd1);
    checkOutput("out_rst_m_valid", 32'(m_valid), 32'd0);
    tick();
    runBatch(tbl[0]);

    // Shortest compute window on the second instance.
    $display("[TB] WAIT_CYCLES=1 instance");
    rst1 = 1'b0;
    tick();
    s_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data1 = 32'(i + 1);
      @(negedge clk);
      checkOutput("w1_s_ready", 32'(s_ready1), 32'd1);
      tick();
    end
    s_valid1 = 1'b0;
    m_ready1 = 1'b1;
    for (int t = 0; t < 100 && bd1 == 0; t++) tick();
    tick();
    m_ready1 = 1'b0;
    checkOutput("w1_mm_low_len", 32'(low1), 32'd1);
    checkOutput("w1_out_count", 32'(out1_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < out1_q.size(); i++)
      checkOutput("w1_m_data", out1_q[i], tbl[0].exp[i]);
    checkOutput("w1_batch_done", 32'(bd1), 32'd1);

    checkOutput("bram_clk_follows", 32'(clk_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule : tb_matrix_bram_host
